// File: rtl/ai_slave_ram.sv
`default_nettype none
// ============================================================================
// ai_slave_ram : AXI4 INCR-burst responder backed by a word-addressed RAM
// Rev 1.0
// ============================================================================
module ai_slave_ram #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_SLV_ID_W    = 7,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int MEM_DEPTH         = 256
) (
  input  logic                         ACLK_i,
  input  logic                         ARESET_i,
  input  logic [TRANS_SLV_ID_W-1:0]    AWID_i,
  input  logic [ADDR_WIDTH-1:0]        AWADDR_i,
  input  logic [TRANS_DATA_LEN_W-1:0]  AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0] AWSIZE_i,
  input  logic                         AWVALID_i,
  output logic                         AWREADY_o,
  input  logic [DATA_WIDTH-1:0]        WDATA_i,
  input  logic                         WLAST_i,
  input  logic                         WVALID_i,
  output logic                         WREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]    BID_o,
  output logic [TRANS_WR_RESP_W-1:0]   BRESP_o,
  output logic                         BVALID_o,
  input  logic                         BREADY_i,
  input  logic [TRANS_SLV_ID_W-1:0]    ARID_i,
  input  logic [ADDR_WIDTH-1:0]        ARADDR_i,
  input  logic [TRANS_DATA_LEN_W-1:0]  ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0] ARSIZE_i,
  input  logic                         ARVALID_i,
  output logic                         ARREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]    RID_o,
  output logic [DATA_WIDTH-1:0]        RDATA_o,
  output logic                         RLAST_o,
  output logic                         RVALID_o,
  input  logic                         RREADY_i
);

  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int BYTE_OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_OKAY   = TRANS_WR_RESP_W'(0);
  localparam logic [TRANS_WR_RESP_W-1:0] RESP_SLVERR = TRANS_WR_RESP_W'(2);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e                    w_state_q, w_state_d;
  logic [TRANS_SLV_ID_W-1:0]   awid_q, awid_d;
  logic [IDX_W-1:0]            widx_q, widx_d;
  logic [TRANS_DATA_LEN_W-1:0] awlen_q, awlen_d;
  logic [TRANS_DATA_LEN_W-1:0] wcnt_q, wcnt_d;
  logic                        werr_q, werr_d;

  r_state_e                    r_state_q, r_state_d;
  logic [TRANS_SLV_ID_W-1:0]   arid_q, arid_d;
  logic [IDX_W-1:0]            ridx_q, ridx_d;
  logic [TRANS_DATA_LEN_W-1:0] arlen_q, arlen_d;
  logic [TRANS_DATA_LEN_W-1:0] rcnt_q, rcnt_d;

  logic mem_we;
  logic unused_bits;

  // Upper address bits and ARSIZE carry no meaning for this RAM.
  assign unused_bits = ^{AWADDR_i, ARADDR_i, ARSIZE_i};

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      widx_q    <= '0;
      awlen_q   <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      ridx_q    <= '0;
      arlen_q   <= '0;
      rcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      widx_q    <= widx_d;
      awlen_q   <= awlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      ridx_q    <= ridx_d;
      arlen_q   <= arlen_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // RAM has no reset so contents survive an aborted burst.
  assign mem_we = (w_state_q == W_DATA) && WVALID_i && !ARESET_i;

  always_ff @(posedge ACLK_i) begin
    if (mem_we) begin
      mem[widx_q] <= WDATA_i;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    widx_d    = widx_q;
    awlen_d   = awlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    AWREADY_o = 1'b0;
    WREADY_o  = 1'b0;
    BVALID_o  = 1'b0;
    BRESP_o   = RESP_OKAY;
    case (w_state_q)
      W_IDLE: begin
        AWREADY_o = 1'b1;
        if (AWVALID_i) begin
          awid_d    = AWID_i;
          widx_d    = AWADDR_i[BYTE_OFF +: IDX_W];
          awlen_d   = AWLEN_i;
          wcnt_d    = '0;
          werr_d    = (AWSIZE_i != TRANS_DATA_SIZE_W'(BYTE_OFF));
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY_o = 1'b1;
        if (WVALID_i) begin
          widx_d = widx_q + IDX_W'(1);
          wcnt_d = wcnt_q + TRANS_DATA_LEN_W'(1);
          if (WLAST_i) begin
            if (wcnt_q != awlen_q) werr_d = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        BVALID_o = 1'b1;
        BRESP_o  = werr_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign BID_o = awid_q;

  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    ridx_d    = ridx_q;
    arlen_d   = arlen_q;
    rcnt_d    = rcnt_q;
    ARREADY_o = 1'b0;
    RVALID_o  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ARREADY_o = 1'b1;
        if (ARVALID_i) begin
          arid_d    = ARID_i;
          ridx_d    = ARADDR_i[BYTE_OFF +: IDX_W];
          arlen_d   = ARLEN_i;
          rcnt_d    = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        RVALID_o = 1'b1;
        if (RREADY_i) begin
          ridx_d = ridx_q + IDX_W'(1);
          rcnt_d = rcnt_q + TRANS_DATA_LEN_W'(1);
          if (rcnt_q == arlen_q) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Combinational read: a same-cycle write is seen only after its edge.
  assign RDATA_o = mem[ridx_q];
  assign RID_o   = arid_q;
  assign RLAST_o = (r_state_q == R_DATA) && (rcnt_q == arlen_q);

endmodule
`default_nettype wire

// File: tb/tb_ai_slave_ram.sv
`default_nettype none
// ============================================================================
// tb_ai_slave_ram : directed self-checking bench for ai_slave_ram
// Rev 1.0
// ============================================================================
module tb_ai_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awlen, awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [6:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [6:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arlen, arsize;
  logic        arvalid, arready;
  logic [6:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ai_slave_ram dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .AWID_i(awid), .AWADDR_i(awaddr), .AWLEN_i(awlen), .AWSIZE_i(awsize),
    .AWVALID_i(awvalid), .AWREADY_o(awready),
    .WDATA_i(wdata), .WLAST_i(wlast), .WVALID_i(wvalid), .WREADY_o(wready),
    .BID_o(bid), .BRESP_o(bresp), .BVALID_o(bvalid), .BREADY_i(bready),
    .ARID_i(arid), .ARADDR_i(araddr), .ARLEN_i(arlen), .ARSIZE_i(arsize),
    .ARVALID_i(arvalid), .ARREADY_o(arready),
    .RID_o(rid), .RDATA_o(rdata), .RLAST_o(rlast), .RVALID_o(rvalid), .RREADY_i(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] id, input logic [31:0] addr, input logic [2:0] len,
                          input logic [2:0] size, input int nbeats, input logic [31:0] d0,
                          input logic [1:0] exp_resp);
    int n = 0;
    while (!awready && n < 20) begin step(); n++; end
    check("aw_ready", awready, 1);
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("w_ready_first", wready, 1);
    for (int b = 0; b < nbeats; b++) begin
      wdata = d0 + 32'(b); wlast = (b == nbeats - 1); wvalid = 1'b1;
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid", bvalid, 1);
    check("b_id", bid, id);
    check("b_resp", bresp, exp_resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("b_valid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [6:0] id, input logic [31:0] addr, input logic [2:0] len,
                         input bit toggle, input logic [31:0] exp [8]);
    int b = 0;
    int cyc = 0;
    check("ar_ready", arready, 1);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    while (b <= int'(len) && cyc < 40) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      check("r_valid", rvalid, 1);
      check("r_data", rdata, exp[b]);
      check("r_id", rid, id);
      check("r_last", rlast, (b == int'(len)));
      step();
      if (rready) b++;
      cyc++;
    end
    rready = 1'b0;
    check("r_done", rvalid, 0);
  endtask

  logic [31:0] e [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arvalid = 1'b0; rready = 1'b0;
    step(); step();
    rst = 1'b0;
    wvalid = 1'b1;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready_stall", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bid", bid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rid", rid, 0);
    wvalid = 1'b0;

    // basic burst at word 4, then read it back with RREADY stalls
    do_write(7'h15, 32'h10, 3'd3, 3'd2, 4, 32'hA0, 2'b00);
    e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
    do_read(7'h2A, 32'h10, 3'd3, 1'b1, e);

    // early WLAST and wrong size both give SLVERR
    do_write(7'h03, 32'h80, 3'd3, 3'd2, 2, 32'hC0, 2'b10);
    e = '{32'hC0, 32'hC1, 0, 0, 0, 0, 0, 0};
    do_read(7'h04, 32'h80, 3'd1, 1'b0, e);
    do_write(7'h05, 32'h90, 3'd0, 3'd1, 1, 32'hD0, 2'b10);

    // index wrap 255 -> 0, upper address bits ignored
    do_write(7'h7F, 32'h1000_03FC, 3'd1, 3'd2, 2, 32'hB0, 2'b00);
    e = '{32'hB0, 32'hB1, 0, 0, 0, 0, 0, 0};
    do_read(7'h01, 32'h3FC, 3'd1, 1'b0, e);
    e = '{32'hB1, 0, 0, 0, 0, 0, 0, 0};
    do_read(7'h02, 32'h0, 3'd0, 1'b0, e);

    // same-cycle write and read of word 8
    do_write(7'h10, 32'h20, 3'd0, 3'd2, 1, 32'h11, 2'b00);
    awid = 7'h11; awaddr = 32'h20; awlen = 3'd0; awsize = 3'd2; awvalid = 1'b1;
    arid = 7'h12; araddr = 32'h20; arlen = 3'd0; arvalid = 1'b1;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'h22; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    check("coll_rvalid", rvalid, 1);
    check("coll_old_data", rdata, 32'h11);
    step();
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    check("coll_bvalid", bvalid, 1);
    check("coll_rdone", rvalid, 0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    e = '{32'h22, 0, 0, 0, 0, 0, 0, 0};
    do_read(7'h13, 32'h20, 3'd0, 1'b0, e);

    // reset during W_DATA after one beat
    awid = 7'h09; awaddr = 32'h40; awlen = 3'd3; awsize = 3'd2; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wdata = 32'h55; wlast = 1'b0; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_bvalid", bvalid, 0);
    check("abort_awready", awready, 1);
    check("abort_wready", wready, 0);
    step();
    check("abort_bvalid_later", bvalid, 0);
    e = '{32'h55, 0, 0, 0, 0, 0, 0, 0};
    do_read(7'h0A, 32'h40, 3'd0, 1'b0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
